// File: rtl/rd_cfg_sequencer.sv
// Read-configuration sequencer.
// Queues read requests, issues them one at a time to a data manager, tracks the
// returning valid beats and enforces a minimum idle gap between issues.
module rd_cfg_sequencer #(
   parameter int unsigned QDEPTH  = 4,   // read-request queue depth
   parameter int unsigned TIMEOUT = 32,  // max quiet cycles in a transaction (1..63)
   parameter int unsigned MIN_GAP = 2    // idle cycles enforced between issues
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       en_i,
   input  logic       rd_req_i,
   input  logic [2:0] pre_amble_sett_i,
   input  logic [1:0] bl_i,
   input  logic       post_amble_sett_i,
   input  logic       read_crc_enable_i,
   input  logic       phy_crc_mode_i,
   input  logic       dm_rddata_valid_i,
   output logic [2:0] dm_pre_amble_o,
   output logic [1:0] dm_bl_o,
   output logic       dm_post_amble_o,
   output logic       dm_crc_en_o,
   output logic       dm_crc_mode_o,
   output logic       dm_rddata_en_o,
   output logic       busy_o,
   output logic       q_full_o,
   output logic       req_drop_o,
   output logic       done_o,
   output logic       timeout_o,
   output logic       unexp_o
);

   localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CntW = $clog2(QDEPTH + 1);
   localparam int unsigned GapW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StBurst,
      StGap
   } state_e;

   // With no gap configured a finished transaction goes straight back to idle.
   localparam state_e StAfterEnd = (MIN_GAP == 0) ? StIdle : StGap;

   // Queue storage: entry layout {pre[2:0], bl[1:0], post, crc_en, crc_mode}
   logic [7:0]      mem_q [QDEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            q_empty, q_full;
   logic            push, pop;
   logic            drop_q, drop_d;

   // Transaction tracking
   state_e          state_q, state_d;
   logic [7:0]      cfg_q, cfg_d;
   logic [4:0]      beat_cnt_q, beat_cnt_d;
   logic [4:0]      exp_beats;
   logic [5:0]      idle_cnt_q, idle_cnt_d;
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
   logic            done, tmo, unexp;

   // Queue occupancy, accept/drop decision and pointer advance
   always_comb begin
      q_empty  = (count_q == '0);
      q_full   = (count_q == CntW'(QDEPTH));
      // A full queue still accepts when the head leaves in the same cycle.
      push     = rd_req_i && (!q_full || pop);
      drop_d   = rd_req_i && !push;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Beats expected for the active transaction, decoded from the held config
   always_comb begin
      unique case (cfg_q[4:3])
         2'b00:   exp_beats = 5'd8;
         2'b01:   exp_beats = 5'd16;
         2'b10:   exp_beats = 5'd4;
         default: exp_beats = 5'd8;
      endcase
      exp_beats = exp_beats + {4'd0, cfg_q[1]};
   end

   // Sequencer next-state, counters and event pulses
   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      beat_cnt_d = beat_cnt_q;
      idle_cnt_d = idle_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      pop        = 1'b0;
      done       = 1'b0;
      tmo        = 1'b0;
      unexp      = 1'b0;
      unique case (state_q)
         StIdle: begin
            unexp = dm_rddata_valid_i;
            if (en_i && !q_empty) begin
               // Head is loaded now so the config is stable while the enable is high.
               state_d = StIssue;
               cfg_d   = mem_q[rd_ptr_q];
            end
         end
         StIssue: begin
            pop        = 1'b1;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
            state_d    = StWait;
         end
         StWait, StBurst: begin
            if (dm_rddata_valid_i) begin
               idle_cnt_d = '0;
               beat_cnt_d = beat_cnt_q + 5'd1;
               if (beat_cnt_d == exp_beats) begin
                  done      = 1'b1;
                  gap_cnt_d = '0;
                  state_d   = StAfterEnd;
               end else begin
                  state_d = StBurst;
               end
            end else begin
               idle_cnt_d = idle_cnt_q + 6'd1;
               if (idle_cnt_q == 6'(TIMEOUT - 1)) begin
                  tmo       = 1'b1;
                  gap_cnt_d = '0;
                  state_d   = StAfterEnd;
               end
            end
         end
         StGap: begin
            unexp = dm_rddata_valid_i;
            if (gap_cnt_q == GapW'(MIN_GAP - 1)) begin
               state_d = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q + GapW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Queue storage write; contents need no reset since the pointers define validity
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {pre_amble_sett_i, bl_i, post_amble_sett_i,
                             read_crc_enable_i, phy_crc_mode_i};
      end
   end

   // State and control registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_q     <= 1'b0;
         cfg_q      <= '0;
         beat_cnt_q <= '0;
         idle_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_q     <= drop_d;
         cfg_q      <= cfg_d;
         beat_cnt_q <= beat_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   // Outputs; same-cycle event pulses are masked while reset is asserted so an
   // aborted burst never reports completion or timeout.
   always_comb begin
      dm_pre_amble_o  = cfg_q[7:5];
      dm_bl_o         = cfg_q[4:3];
      dm_post_amble_o = cfg_q[2];
      dm_crc_en_o     = cfg_q[1];
      dm_crc_mode_o   = cfg_q[0];
      dm_rddata_en_o  = (state_q == StIssue);
      busy_o          = (state_q == StIssue) || (state_q == StWait) || (state_q == StBurst);
      q_full_o        = q_full;
      req_drop_o      = drop_q;
      done_o          = done && reset_n_i;
      timeout_o       = tmo && reset_n_i;
      unexp_o         = unexp && reset_n_i;
   end

endmodule

// File: tb/tb_rd_cfg_sequencer.sv
// Bench for rd_cfg_sequencer: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the sequencer.
module tb_rd_cfg_sequencer;

   localparam int QDEPTH  = 4;
   localparam int TIMEOUT = 32;
   localparam int MIN_GAP = 2;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       rd_req;
   logic [2:0] rq_pre;
   logic [1:0] rq_bl;
   logic       rq_post;
   logic       rq_crc;
   logic       rq_mode;
   logic       valid;
   logic [2:0] dm_pre;
   logic [1:0] dm_bl;
   logic       dm_post;
   logic       dm_crc;
   logic       dm_mode;
   logic       dm_en;
   logic       busy;
   logic       qfull;
   logic       drop;
   logic       done;
   logic       tmo;
   logic       unexp;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   rd_cfg_sequencer #(
      .QDEPTH (QDEPTH),
      .TIMEOUT(TIMEOUT),
      .MIN_GAP(MIN_GAP)
   ) dut (
      .clk_i            (clk),
      .reset_n_i        (rst_n),
      .en_i             (en),
      .rd_req_i         (rd_req),
      .pre_amble_sett_i (rq_pre),
      .bl_i             (rq_bl),
      .post_amble_sett_i(rq_post),
      .read_crc_enable_i(rq_crc),
      .phy_crc_mode_i   (rq_mode),
      .dm_rddata_valid_i(valid),
      .dm_pre_amble_o   (dm_pre),
      .dm_bl_o          (dm_bl),
      .dm_post_amble_o  (dm_post),
      .dm_crc_en_o      (dm_crc),
      .dm_crc_mode_o    (dm_mode),
      .dm_rddata_en_o   (dm_en),
      .busy_o           (busy),
      .q_full_o         (qfull),
      .req_drop_o       (drop),
      .done_o           (done),
      .timeout_o        (tmo),
      .unexp_o          (unexp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic int beats_for(input logic [1:0] b, input logic crc);
      int n;
      case (b)
         2'b00:   n = 8;
         2'b01:   n = 16;
         2'b10:   n = 4;
         default: n = 8;
      endcase
      return n + (crc ? 1 : 0);
   endfunction

   // ---------------- transaction-level model ----------------
   logic [7:0] mq[$];
   bit         m_issuing = 0;
   bit         m_in_txn  = 0;
   int         m_left    = 0;
   int         m_quiet   = 0;
   int         m_gap     = 0;
   logic [7:0] m_cfg     = '0;
   bit         m_drop    = 0;
   bit         e_busy, e_done, e_tmo, e_unexp, acc, pop_now;
   int         was_size;
   logic [7:0] head;

   // Compare DUT outputs with the model, then advance the model across the next edge
   always @(negedge clk) begin
      e_busy  = m_issuing || m_in_txn;
      e_done  = rst_n && m_in_txn && valid && (m_left == 1);
      e_tmo   = rst_n && m_in_txn && !valid && (m_quiet == TIMEOUT - 1);
      e_unexp = rst_n && valid && !m_issuing && !m_in_txn;
      chk("m_busy", busy, e_busy);
      chk("m_dm_en", dm_en, m_issuing);
      chk("m_cfg", {dm_pre, dm_bl, dm_post, dm_crc, dm_mode}, m_cfg);
      chk("m_qfull", qfull, mq.size() == QDEPTH);
      chk("m_drop", drop, m_drop);
      chk("m_done", done, e_done);
      chk("m_timeout", tmo, e_tmo);
      chk("m_unexp", unexp, e_unexp);
      if (!rst_n) begin
         mq.delete();
         m_issuing = 0;
         m_in_txn  = 0;
         m_left    = 0;
         m_quiet   = 0;
         m_gap     = 0;
         m_cfg     = '0;
         m_drop    = 0;
      end else begin
         was_size = mq.size();
         head     = (was_size != 0) ? mq[0] : 8'h00;
         pop_now  = m_issuing;
         acc      = rd_req && ((was_size < QDEPTH) || pop_now);
         m_drop   = rd_req && !acc;
         if (pop_now) void'(mq.pop_front());
         if (acc) mq.push_back({rq_pre, rq_bl, rq_post, rq_crc, rq_mode});
         if (m_issuing) begin
            m_issuing = 0;
            m_in_txn  = 1;
            m_left    = beats_for(m_cfg[4:3], m_cfg[1]);
            m_quiet   = 0;
         end else if (m_in_txn) begin
            if (valid) begin
               m_left--;
               m_quiet = 0;
               if (m_left == 0) begin
                  m_in_txn = 0;
                  m_gap    = MIN_GAP;
               end
            end else begin
               m_quiet++;
               if (m_quiet == TIMEOUT) begin
                  m_in_txn = 0;
                  m_gap    = MIN_GAP;
               end
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end else if (en && was_size != 0) begin
            m_issuing = 1;
            m_cfg     = head;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      rd_req = 1'b1;
      {rq_pre, rq_bl, rq_post, rq_crc, rq_mode} = c;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         valid = 1'b1;
         tick();
      end
      valid = 1'b0;
   endtask

   // Leaves the caller at the negedge of the issue cycle when an issue is seen
   task automatic wait_issue(input string name);
      bit found;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dm_en === 1'b1) begin
            found = 1;
            break;
         end
         tick();
      end
      chk(name, found, 1);
   endtask

   logic [7:0] tab [5];
   int         last_issue;
   int         k_seen;
   int         en_cnt;
   bit         quiet_mode;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0] = 8'hA1; tab[1] = 8'h4A; tab[2] = 8'hF7; tab[3] = 8'h12; tab[4] = 8'h3C;
      rst_n = 1'b0; en = 1'b0; rd_req = 1'b0; valid = 1'b0;
      {rq_pre, rq_bl, rq_post, rq_crc, rq_mode} = '0;
      repeat (3) tick();

      // Reset state
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_qfull", qfull, 0);
      chk("rst_outs", {dm_pre, dm_bl, dm_post, dm_crc, dm_mode, dm_en, drop, done, tmo, unexp}, 0);
      tick();

      // Single bl=00 request, beats start 3 cycles after the enable
      rst_n = 1'b1; en = 1'b1;
      send(8'hA5);
      wait_issue("r20_issue");
      chk("r20_cfg", {dm_pre, dm_bl, dm_post, dm_crc, dm_mode}, 8'hA5);
      tick(); tick(); tick();
      for (int i = 1; i <= 8; i++) begin
         valid = 1'b1;
         @(negedge clk);
         chk("r20_done", done, (i == 8));
         tick();
      end
      valid = 1'b0;
      @(negedge clk);
      chk("r20_busy_after", busy, 0);
      tick();

      // bl=01 with CRC: 17 beats separated by one-cycle gaps
      send(8'b010_01_0_1_0);
      wait_issue("r21_issue");
      tick();
      for (int i = 1; i <= 17; i++) begin
         valid = 1'b1;
         @(negedge clk);
         chk("r21_done", done, (i == 17));
         chk("r21_tmo", tmo, 0);
         tick();
         valid = 1'b0;
         if (i < 17) tick();
      end
      repeat (4) tick();

      // Valid while idle
      valid = 1'b1;
      @(negedge clk);
      chk("r25_unexp", unexp, 1);
      chk("r25_busy", busy, 0);
      tick();
      valid = 1'b0;
      @(negedge clk);
      chk("r25_idle", busy, 0);
      tick();

      // Five back-to-back requests with issue disabled
      en = 1'b0;
      for (int i = 0; i < 5; i++) send(tab[i]);
      @(negedge clk);
      chk("r22_qfull", qfull, 1);
      chk("r22_drop", drop, 1);
      tick();
      en = 1'b1;
      last_issue = 0;
      for (int k = 0; k < 4; k++) begin
         wait_issue("r22_issue");
         chk("r22_cfg", {dm_pre, dm_bl, dm_post, dm_crc, dm_mode}, tab[k]);
         if (k > 0) chk("r22_sep", (cyc - last_issue) > MIN_GAP, 1);
         last_issue = cyc;
         tick();
         feed(beats_for(tab[k][4:3], tab[k][1]));
      end
      repeat (4) tick();

      // Timeout with a second request waiting behind it
      send(8'h00);
      send(8'h6F);
      wait_issue("r23_issue");
      k_seen = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         @(negedge clk);
         if (tmo === 1'b1) begin
            k_seen = i;
            break;
         end
      end
      chk("r23_tmo_cycle", k_seen, TIMEOUT);
      tick();
      wait_issue("r23_next");
      chk("r23_cfg", {dm_pre, dm_bl, dm_post, dm_crc, dm_mode}, 8'h6F);
      tick();
      feed(beats_for(2'b01, 1'b1));
      repeat (4) tick();

      // Reset in the middle of a burst with two entries still queued
      en = 1'b0;
      send(8'h20); send(8'h44); send(8'h88);
      en = 1'b1;
      wait_issue("r24_issue");
      tick();
      feed(3);
      rst_n = 1'b0;
      valid = 1'b1;
      @(negedge clk);
      chk("r24_no_done", done, 0);
      tick();
      rst_n = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      chk("r24_outs", {busy, qfull, dm_en, drop, dm_pre, dm_bl, dm_post, dm_crc, dm_mode}, 0);
      en_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         if (dm_en === 1'b1) en_cnt++;
      end
      chk("r24_empty", en_cnt, 0);
      tick();
      send(8'hC9);
      wait_issue("r24_new");
      chk("r24_cfg", {dm_pre, dm_bl, dm_post, dm_crc, dm_mode}, 8'hC9);
      tick();
      feed(beats_for(2'b01, 1'b0));
      repeat (4) tick();

      // Randomized traffic, checked cycle by cycle against the model
      quiet_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         quiet_mode = ((i % 400) >= 350);
         rst_n  = ($urandom_range(0, 299) != 0);
         en     = ($urandom_range(0, 9) != 0);
         rd_req = ($urandom_range(0, 3) == 0);
         {rq_pre, rq_bl, rq_post, rq_crc, rq_mode} = 8'($urandom);
         valid  = quiet_mode ? 1'b0 : ($urandom_range(0, 2) != 0);
         tick();
      end
      rst_n = 1'b1; rd_req = 1'b0; valid = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rd_cfg_sequencer.md
RD_CFG_SEQUENCER -- requirements
Module: rd_cfg_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
- QDEPTH, 4, read-request queue depth
- TIMEOUT, 32, max cycles waiting for or between valid beats
- MIN_GAP, 2, idle cycles enforced between consecutive issues
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock; all logic on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- en_i  in  1  issue enable
- rd_req_i  in  1  one-cycle read request strobe, qualified with the config fields below
- pre_amble_sett_i  in  3  request preamble setting
- bl_i  in  2  request burst length code
- post_amble_sett_i  in  1  request postamble setting
- read_crc_enable_i  in  1  request read-CRC enable
- phy_crc_mode_i  in  1  request PHY CRC mode
- dm_rddata_valid_i  in  1  data-manager output-beat valid
- dm_pre_amble_o  out  3  config to data manager
- dm_bl_o  out  2  config to data manager
- dm_post_amble_o  out  1  config to data manager
- dm_crc_en_o  out  1  config to data manager
- dm_crc_mode_o  out  1  config to data manager
- dm_rddata_en_o  out  1  one-cycle read-enable pulse to data manager
- busy_o  out  1  a transaction is in flight
- q_full_o  out  1  queue holds QDEPTH entries
- req_drop_o  out  1  one-cycle pulse when a request is rejected
- done_o  out  1  one-cycle pulse when a burst completes
- timeout_o  out  1  one-cycle pulse when a burst is aborted
- unexp_o  out  1  one-cycle pulse on valid outside a burst

Function
REQ-003 SHALL store each accepted request as an 8-bit entry {pre,bl,post,crc_en,crc_mode} in a QDEPTH-entry FIFO.
REQ-004 SHALL accept rd_req_i when count<QDEPTH, or when count==QDEPTH and a pop occurs in the same cycle; otherwise it SHALL drop the request and pulse req_drop_o the next cycle.
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, BURST, GAP.
REQ-006 IDLE->ISSUE SHALL occur when en_i=1 and the queue is non-empty.
REQ-007 In ISSUE the block SHALL pop the head entry, register it onto the dm_* config outputs, and assert dm_rddata_en_o for exactly that cycle; next state is WAIT.
REQ-008 The dm_* config outputs SHALL hold the popped entry unchanged until the next ISSUE.
REQ-009 Expected valid-beat count SHALL be: bl 00->8, 01->16, 10->4, 11->8, plus 1 when crc_en=1.
REQ-010 WAIT->BURST SHALL occur on the first dm_rddata_valid_i=1, counting that beat as 1.
REQ-011 In BURST the block SHALL count only cycles with valid=1. Valid-low gaps SHALL NOT reset the count.
REQ-012 When the count reaches the expected value, the block SHALL pulse done_o in the same cycle and move to GAP.
REQ-013 A 6-bit idle counter SHALL increment on every valid=0 cycle in WAIT/BURST and clear on valid=1. At value TIMEOUT the block SHALL pulse timeout_o and move to GAP.
REQ-014 GAP SHALL last MIN_GAP cycles and then return to IDLE. Valid=1 in GAP or IDLE SHALL pulse unexp_o and be otherwise ignored.
REQ-015 en_i=0 SHALL block only IDLE->ISSUE. An in-flight transaction SHALL complete normally.
REQ-016 busy_o SHALL be 1 in ISSUE, WAIT and BURST. q_full_o SHALL equal (count==QDEPTH).
REQ-017 Simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order. Pointers SHALL wrap modulo QDEPTH.

Reset
REQ-018 reset_n_i=0 at a clock edge SHALL force IDLE, empty the FIFO, clear all counters, and drive every output to 0. This applies also mid-burst; no done_o or timeout_o pulse is generated for the aborted burst.
REQ-019 After reset release, the first ISSUE SHALL occur no earlier than the cycle after a request is accepted with en_i=1.

Verification
REQ-020 Single request bl=00, crc=0, with 8 valid beats starting 3 cycles after dm_rddata_en_o -> one dm_rddata_en_o pulse, done_o on the 8th beat, busy_o low after.
REQ-021 bl=01, crc=1, with 17 valid beats interleaved with 1-cycle valid-low gaps -> done_o on the 17th beat; no timeout_o.
REQ-022 5 back-to-back requests with en_i=0 -> first 4 accepted (q_full_o=1), 5th dropped (req_drop_o pulse). With en_i=1, the 4 issues occur in order, each separated by at least MIN_GAP+ cycles, and the dm_* config matches each entry.
REQ-023 Request issued, no valid for 32 cycles -> timeout_o pulse, GAP, next queued request issued.
REQ-024 Reset asserted mid-BURST with 2 entries queued -> all outputs 0, queue empty, no done_o; a new request issues normally.
REQ-025 Valid pulse while IDLE -> unexp_o pulse; FSM stays IDLE.
